freq_meter: RTL and testbench

//  Gated frequency counter: counts rising edges of an asynchronous input over a fixed

---
 rtl/freq_meter.sv | 118 +++++++++++
 tb/tb_freq_meter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of sig_in over CLK_HZ/GATE_DIV clocks and reports Hz.
// Define FREQ_METER_CONT_EN for continuous back-to-back windows; otherwise a measurement runs per start pulse.
module freq_meter #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int GATE_DIV = 1,
   parameter int OUT_W    = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic [OUT_W-1:0] fre,
   output logic             fre_valid,
   output logic             overflow
);

   localparam int GATE_CYC = CLK_HZ / GATE_DIV;
   localparam int GATE_W   = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
   localparam int CNT_W    = OUT_W + 1;
   localparam int PROD_W   = OUT_W + $clog2(GATE_DIV + 1) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GATE = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
   localparam logic [PROD_W-1:0] FRE_MAX   = {{(PROD_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};
   localparam logic [PROD_W-1:0] DIV_P     = PROD_W'(GATE_DIV);

   logic [1:0]        state_q, state_d;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic [OUT_W-1:0]  fre_q, fre_d;
   logic              ovf_q, ovf_d;
   logic [2:0]        sync_q;
   logic              edge_w;
   logic              start_go;
   logic [PROD_W-1:0] prod;

`ifdef FREQ_METER_CONT_EN
   // IDLE is only ever reached out of reset here, so leave it immediately.
   logic unused_start;
   assign unused_start = start;
   assign start_go     = 1'b1;
`else
   assign start_go = start;
`endif

   // Two metastability flops followed by a history flop for edge detection.
   assign edge_w = sync_q[1] & ~sync_q[2];

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      fre_d      = fre_q;
      ovf_d      = ovf_q;
      prod       = '0;
      case (state_q)
         ST_IDLE: begin
            if (start_go) begin
               state_d    = ST_GATE;
               gate_cnt_d = '0;
               edge_cnt_d = '0;
            end
         end
         ST_GATE: begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            if (edge_w && (edge_cnt_q != {CNT_W{1'b1}})) begin
               edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
            // Result is latched on the way into DONE so it is visible alongside fre_valid,
            // and uses the updated count so an edge on the final gate cycle is included.
            if (gate_cnt_q == GATE_LAST) begin
               state_d = ST_DONE;
               prod    = {{(PROD_W - CNT_W){1'b0}}, edge_cnt_d} * DIV_P;
               ovf_d   = (prod > FRE_MAX);
               fre_d   = (prod > FRE_MAX) ? {OUT_W{1'b1}} : prod[OUT_W-1:0];
            end
         end
         ST_DONE: begin
`ifdef FREQ_METER_CONT_EN
            state_d    = ST_GATE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         fre_q      <= '0;
         ovf_q      <= 1'b0;
         sync_q     <= '0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         fre_q      <= fre_d;
         ovf_q      <= ovf_d;
         sync_q     <= {sync_q[1:0], sig_in};
      end
   end

   assign busy      = (state_q == ST_GATE);
   assign fre_valid = (state_q == ST_DONE);
   assign fre       = fre_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboarded bench for freq_meter: a small gate (250 clocks, x4 scaling, 8-bit result) so overflow is reachable.
module tb_freq_meter;

   localparam int CLK_HZ   = 1000;
   localparam int GATE_DIV = 4;
   localparam int OUT_W    = 8;
   localparam int N        = CLK_HZ / GATE_DIV;
   localparam int MAXF     = (1 << OUT_W) - 1;
   localparam int LEN      = 8192;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sig_in = 1'b0;
   logic             start = 1'b0;
   logic             busy;
   logic             fre_valid;
   logic             overflow;
   logic [OUT_W-1:0] fre;

   freq_meter #(
      .CLK_HZ  (CLK_HZ),
      .GATE_DIV(GATE_DIV),
      .OUT_W   (OUT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in),
      .start    (start),
      .busy     (busy),
      .fre      (fre),
      .fre_valid(fre_valid),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int edges;
      int fre;
      int ov;
   } exp_t;

   exp_t sb[$];
   bit   pat[LEN];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;
   int   hold_fre = 0;
   int   hold_ov = 0;
   int   exp_busy;
   exp_t got;

   // cyc is the index of the next posedge as seen from a negedge.
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) sig_in = pat[cyc % LEN];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // The meter sees the pin two clocks late, so its window covers rising transitions
   // that land between samples p-2 and p+N-2 of the value sampled at each posedge.
   function automatic int count_edges(input int p);
      int cnt = 0;
      for (int m = p - 1; m <= p + N - 2; m++) begin
         if (!pat[(m - 1) % LEN] && pat[m % LEN]) cnt++;
      end
      return cnt;
   endfunction

   task automatic fill(input int mode, input int from, input int len);
      int h;
      int ph;
      h  = (mode == 2) ? 5 : (mode == 5) ? 1 : int'($urandom_range(1, 8));
      ph = int'($urandom_range(0, 15));
      for (int i = 0; i < len; i++) begin
         case (mode)
            0:       pat[(from + i) % LEN] = 1'b0;
            1:       pat[(from + i) % LEN] = 1'b1;
            4:       pat[(from + i) % LEN] = 1'($urandom_range(0, 1));
            default: pat[(from + i) % LEN] = 1'(((from + i + ph) / h) % 2);
         endcase
      end
   endtask

   task automatic do_start(output int p);
      exp_t e;
      int prod;
      @(negedge clk);
      start = 1'b1;
      p = cyc;
      e.p = p;
      e.edges = count_edges(p);
      prod = e.edges * GATE_DIV;
      e.fre = (prod > MAXF) ? MAXF : prod;
      e.ov = (prod > MAXF) ? 1 : 0;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_one(input int mode);
      int p;
      fill(mode, cyc + 1, N + 60);
      repeat ($urandom_range(3, 8)) @(negedge clk);
      do_start(p);
      for (int k = 0; k < N + 10 && sb.size() > 0; k++) @(negedge clk);
      repeat ($urandom_range(1, 6)) @(negedge clk);
   endtask

   task automatic apply_reset(input bit with_start);
      @(negedge clk);
      rst = 1'b1;
      start = with_start;
      @(posedge clk);
      #1;
      sb.delete();
      hold_fre = 0;
      hold_ov = 0;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check("reset_fre", int'(fre), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_ovf", int'(overflow), 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         exp_busy = 0;
         if (sb.size() > 0 && cyc >= sb[0].p + 1 && cyc <= sb[0].p + N) exp_busy = 1;
         check("busy", int'(busy), exp_busy);
         if (fre_valid) begin
            if (sb.size() == 0) begin
               check("spurious_valid", int'(fre_valid), 0);
            end else begin
               got = sb.pop_front();
               check("valid_cycle", cyc, got.p + N + 1);
               check("fre", int'(fre), got.fre);
               check("overflow", int'(overflow), got.ov);
               hold_fre = got.fre;
               hold_ov = got.ov;
               $display("txn start=%0d edges=%0d fre=%0d ovf=%0b exp_fre=%0d exp_ovf=%0d",
                        got.p, got.edges, fre, overflow, got.fre, got.ov);
            end
         end else begin
            check("fre_hold", int'(fre), hold_fre);
            check("ovf_hold", int'(overflow), hold_ov);
            if (sb.size() > 0 && cyc > sb[0].p + N + 1) begin
               check("valid_timeout", int'(fre_valid), 1);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("init_fre", int'(fre), 0);
      check("init_busy", int'(busy), 0);
      check("init_valid", int'(fre_valid), 0);
      check("init_ovf", int'(overflow), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // toggle/5, constant 0, max rate (saturates), constant 1, then random mixes
      run_one(2);
      run_one(0);
      run_one(5);
      run_one(1);
      for (int t = 0; t < 5; t++) run_one(int'($urandom_range(3, 4)));
      run_one(5);
      run_one(0);

      // start during the gate and during DONE must be ignored
      fill(3, cyc + 1, N + 120);
      repeat (4) @(negedge clk);
      do_start(p);
      while (cyc < p + N / 2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < p + N + 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (N / 5) @(negedge clk);

      // reset halfway through a gate aborts it
      fill(2, cyc + 1, 2 * N + 60);
      repeat (4) @(negedge clk);
      do_start(p);
      while (cyc < p + N / 2) @(negedge clk);
      apply_reset(1'b0);
      repeat (N + 20) @(negedge clk);

      // start together with reset: reset wins
      apply_reset(1'b1);
      repeat (20) @(negedge clk);

      run_one(2);
      run_one(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
